draw_sequencer: RTL and testbench
=================================

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_STATUS, default 6: number of status-overlay channels, legal range 1..16.
REQ-002 SHALL have parameter NUM_ITEMS, default 5: number of item channels, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: clock; reset is synchronous to clk, active-high.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port go, input, 1: advances the wait states.
REQ-006 SHALL have port go_start, input, 1: leaves the start screen; also restarts from game-over.
REQ-007 SHALL have port plot_done, input, 1: one-cycle pulse marking completion of the current draw.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle frame strobe.
REQ-009 SHALL have port deceased, input, 1: pet is dead.
REQ-010 SHALL have port status_en, input, NUM_STATUS: per-channel overlay request (hunger, bored, sick, ...).
REQ-011 SHALL have port item_given, input, NUM_ITEMS: per-channel item request.
REQ-012 SHALL have port draw_start, output, 1: draw the start screen.
REQ-013 SHALL have port draw_bg, output, 1: draw the game background.
REQ-014 SHALL have port draw_status, output, NUM_STATUS: one-hot strobe selecting the overlay to draw.
REQ-015 SHALL have port draw_item, output, NUM_ITEMS: one-hot strobe selecting the item to draw.
REQ-016 SHALL have port draw_gameover, output, 1: draw the game-over screen.
REQ-017 SHALL have port move_objects, output, 1: one-cycle object-update strobe.
REQ-018 SHALL have port overrun_cnt, output, 8: count of frame ticks arriving outside S_WAIT_TICK.
REQ-019 SHALL have port state, output, 4: current state encoding.

Function
REQ-020 SHALL encode states as: S_IDLE=0, S_START=1, S_WAIT_BG=2, S_BG=3, S_SCAN=4, S_STATUS=5, S_ITEM=6, S_MOVE=7, S_WAIT_TICK=8, S_GAMEOVER=9.
REQ-021 SHALL decode all draw and move outputs combinationally from state and the latched channel index, so each output is asserted in exactly one state and 0 elsewhere.
REQ-022 S_IDLE: go -> S_START. S_START: draw_start=1, go_start -> S_WAIT_BG. S_WAIT_BG: go -> S_BG.
REQ-023 S_BG: draw_bg=1; on plot_done, deceased=1 -> S_GAMEOVER; otherwise -> S_SCAN, with status_en snapshotted into the pending mask and item_given into the item snapshot on that edge.
REQ-024 Input changes after the snapshot SHALL NOT affect the current frame.
REQ-025 S_SCAN (1 cycle): if the pending mask is nonzero, latch the lowest set index, clear that bit, and go -> S_STATUS.
REQ-026 S_SCAN with an empty mask: go -> S_ITEM if the item snapshot is nonzero (latch its lowest set index), else -> S_WAIT_TICK.
REQ-027 S_STATUS: draw_status[idx]=1; on plot_done -> S_SCAN. All enabled overlays SHALL be drawn in one frame, in ascending index order.
REQ-028 S_ITEM: draw_item[idx]=1; on plot_done -> S_MOVE. At most one item SHALL be drawn per frame, the lowest-index one.
REQ-029 S_MOVE: move_objects=1 for exactly one cycle, then -> S_WAIT_TICK.
REQ-030 S_WAIT_TICK: go -> S_BG if frame_tick=1 or tick_pending=1, and clear tick_pending on that transition.
REQ-031 A frame_tick in S_BG, S_SCAN, S_STATUS, S_ITEM or S_MOVE SHALL set tick_pending and increment overrun_cnt, saturating at 255.
REQ-032 A frame_tick while tick_pending=1 SHALL also increment overrun_cnt; ticks are not queued beyond one.
REQ-033 S_GAMEOVER: draw_gameover=1; plot_done sets go_done; go_start with go_done=1 -> S_IDLE and clears overrun_cnt; go_start before plot_done is ignored.
REQ-034 plot_done in any state not listed above SHALL be ignored. frame_tick in S_IDLE, S_START, S_WAIT_BG or S_GAMEOVER SHALL be ignored and not counted.
REQ-035 When plot_done and frame_tick coincide in S_STATUS, the machine SHALL take the plot_done transition and set tick_pending.

Reset
REQ-036 On reset: state=S_IDLE; pending mask, item snapshot, idx, tick_pending, go_done and overrun_cnt = 0; all draw and move outputs = 0.
REQ-037 Reset SHALL take priority over every transition, including mid-draw; a plot_done in the same cycle as reset is discarded.

Verification
REQ-038 go, go_start, go, then plot_done in S_BG with status_en=6'b100101 and item_given=0 -> draw_status = 000001, then 000100, then 100000 (each until plot_done), then S_WAIT_TICK; move_objects never asserted.
REQ-039 status_en=0 and item_given=5'b01100 at the BG plot_done -> draw_item=00100 only, then move_objects for 1 cycle, then state=8.
REQ-040 frame_tick pulsed twice during S_STATUS -> overrun_cnt=2; entry to S_WAIT_TICK -> S_BG on the next cycle with no new tick.
REQ-041 deceased=1 at the BG plot_done -> state=9; go_start before plot_done -> stays in 9; plot_done then go_start -> state=0 and overrun_cnt=0.
REQ-042 status_en toggled to 0 during S_STATUS -> the remaining snapshotted overlays are still drawn; 300 overrun ticks -> overrun_cnt=255.
REQ-043 reset asserted in S_ITEM coincident with plot_done -> next cycle state=0, all outputs 0, no move_objects pulse.

Source files
------------

// File: rtl/draw_sequencer.sv
// Frame draw sequencer: start screen, then per-frame background, enabled status
// overlays (ascending), at most one item plus an object update, then frame-tick wait.
module draw_sequencer #(
  parameter int NUM_STATUS = 6,
  parameter int NUM_ITEMS  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  go_start,
  input  logic                  plot_done,
  input  logic                  frame_tick,
  input  logic                  deceased,
  input  logic [NUM_STATUS-1:0] status_en,
  input  logic [NUM_ITEMS-1:0]  item_given,
  output logic                  draw_start,
  output logic                  draw_bg,
  output logic [NUM_STATUS-1:0] draw_status,
  output logic [NUM_ITEMS-1:0]  draw_item,
  output logic                  draw_gameover,
  output logic                  move_objects,
  output logic [7:0]            overrun_cnt,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_WAIT_BG   = 4'd2,
    S_BG        = 4'd3,
    S_SCAN      = 4'd4,
    S_STATUS    = 4'd5,
    S_ITEM      = 4'd6,
    S_MOVE      = 4'd7,
    S_WAIT_TICK = 4'd8,
    S_GAMEOVER  = 4'd9
  } state_t;

  state_t                cur_state;
  logic [NUM_STATUS-1:0] pending;
  logic [NUM_ITEMS-1:0]  items;
  logic [3:0]            idx;
  logic                  tick_pending;
  logic                  go_done;
  logic                  busy;

  function automatic logic [3:0] lowest_status(input logic [NUM_STATUS-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_STATUS - 1; i >= 0; i--)
      if (v[i]) r = i[3:0];
    return r;
  endfunction

  function automatic logic [3:0] lowest_item(input logic [NUM_ITEMS-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--)
      if (v[i]) r = i[3:0];
    return r;
  endfunction

  // States in which a frame tick means the frame ran long.
  assign busy = (cur_state == S_BG) || (cur_state == S_SCAN) || (cur_state == S_STATUS) ||
                (cur_state == S_ITEM) || (cur_state == S_MOVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= S_IDLE;
      pending      <= '0;
      items        <= '0;
      idx          <= 4'd0;
      tick_pending <= 1'b0;
      go_done      <= 1'b0;
      overrun_cnt  <= 8'd0;
    end else begin
      if (frame_tick && busy) begin
        tick_pending <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (cur_state)
        S_IDLE:    if (go) cur_state <= S_START;
        S_START:   if (go_start) cur_state <= S_WAIT_BG;
        S_WAIT_BG: if (go) cur_state <= S_BG;
        S_BG: begin
          if (plot_done) begin
            if (deceased) begin
              cur_state <= S_GAMEOVER;
              go_done   <= 1'b0;
            end else begin
              cur_state <= S_SCAN;
              pending   <= status_en;
              items     <= item_given;
            end
          end
        end
        S_SCAN: begin
          if (|pending) begin
            idx       <= lowest_status(pending);
            pending   <= pending & (pending - 1'b1);
            cur_state <= S_STATUS;
          end else if (|items) begin
            idx       <= lowest_item(items);
            cur_state <= S_ITEM;
          end else begin
            cur_state <= S_WAIT_TICK;
          end
        end
        S_STATUS: if (plot_done) cur_state <= S_SCAN;
        S_ITEM:   if (plot_done) cur_state <= S_MOVE;
        S_MOVE:   cur_state <= S_WAIT_TICK;
        S_WAIT_TICK: begin
          if (frame_tick || tick_pending) begin
            cur_state    <= S_BG;
            tick_pending <= 1'b0;
            // A tick landing on an already-pending tick is dropped, so count it.
            if (frame_tick && tick_pending && overrun_cnt != 8'hFF)
              overrun_cnt <= overrun_cnt + 8'd1;
          end
        end
        S_GAMEOVER: begin
          if (plot_done) go_done <= 1'b1;
          if (go_start && go_done) begin
            cur_state    <= S_IDLE;
            overrun_cnt  <= 8'd0;
            go_done      <= 1'b0;
            tick_pending <= 1'b0;
          end
        end
        default: cur_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    draw_start    = (cur_state == S_START);
    draw_bg       = (cur_state == S_BG);
    draw_gameover = (cur_state == S_GAMEOVER);
    move_objects  = (cur_state == S_MOVE);
    draw_status   = '0;
    draw_item     = '0;
    for (int i = 0; i < NUM_STATUS; i++)
      draw_status[i] = (cur_state == S_STATUS) && (idx == i[3:0]);
    for (int i = 0; i < NUM_ITEMS; i++)
      draw_item[i] = (cur_state == S_ITEM) && (idx == i[3:0]);
  end

  assign state = cur_state;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: frame sequencing, overlay ordering, item/move,
// overrun counting and saturation, game-over handshake and reset mid-draw.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset, go, go_start, plot_done, frame_tick, deceased;
  logic [5:0] status_en;
  logic [4:0] item_given;
  logic       draw_start, draw_bg, draw_gameover, move_objects;
  logic [5:0] draw_status;
  logic [4:0] draw_item;
  logic [7:0] overrun_cnt;
  logic [3:0] state;

  int n_vec = 0;
  int n_bad = 0;
  int move_cnt = 0;
  int move_base;

  draw_sequencer #(.NUM_STATUS(6), .NUM_ITEMS(5)) dut (
    .clk(clk), .reset(reset), .go(go), .go_start(go_start), .plot_done(plot_done),
    .frame_tick(frame_tick), .deceased(deceased), .status_en(status_en),
    .item_given(item_given), .draw_start(draw_start), .draw_bg(draw_bg),
    .draw_status(draw_status), .draw_item(draw_item), .draw_gameover(draw_gameover),
    .move_objects(move_objects), .overrun_cnt(overrun_cnt), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (move_objects) move_cnt <= move_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_plot();
    plot_done = 1'b1;
    step();
    plot_done = 1'b0;
  endtask

  task automatic to_bg();
    go = 1'b1;
    step();
    check_val("start_state", state, 4'd1);
    check_val("draw_start", draw_start, 1'b1);
    go = 1'b0; go_start = 1'b1;
    step();
    go_start = 1'b0;
    check_val("wait_bg_state", state, 4'd2);
    go = 1'b1;
    step();
    go = 1'b0;
    check_val("bg_state", state, 4'd3);
    check_val("draw_bg", draw_bg, 1'b1);
  endtask

  initial begin
    reset = 1'b1; go = 0; go_start = 0; plot_done = 0; frame_tick = 0; deceased = 0;
    status_en = '0; item_given = '0;
    step(); step();
    reset = 1'b0;
    check_val("rst_state", state, 4'd0);
    check_val("rst_outs", {draw_start, draw_bg, draw_status, draw_item, draw_gameover, move_objects}, 0);
    check_val("rst_overrun", overrun_cnt, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_val("idle_tick_ignored", overrun_cnt, 0);
    check_val("idle_hold", state, 4'd0);

    // Three overlays in ascending order; input cleared after snapshot.
    to_bg();
    move_base = move_cnt;
    status_en = 6'b100101; item_given = 5'b0;
    pulse_plot();
    status_en = 6'b0;
    check_val("scan_state", state, 4'd4);
    check_val("scan_no_draw", draw_status, 6'b0);
    step();
    check_val("status0", draw_status, 6'b000001);
    step();
    check_val("status0_hold", draw_status, 6'b000001);
    pulse_plot(); step();
    check_val("status2", draw_status, 6'b000100);
    pulse_plot(); step();
    check_val("status5", draw_status, 6'b100000);
    pulse_plot(); step();
    check_val("wait_tick_state", state, 4'd8);
    check_val("no_move", move_cnt - move_base, 0);
    go = 1'b1;
    step();
    check_val("wait_tick_hold", state, 4'd8);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_val("tick_to_bg", state, 4'd3);
    check_val("no_overrun", overrun_cnt, 0);

    // Lowest item only, then a single move pulse.
    move_base = move_cnt;
    status_en = 6'b0; item_given = 5'b01100;
    pulse_plot(); step();
    check_val("item_state", state, 4'd6);
    check_val("item_sel", draw_item, 5'b00100);
    pulse_plot();
    check_val("move_state", state, 4'd7);
    check_val("move_high", move_objects, 1'b1);
    step();
    check_val("after_move", state, 4'd8);
    check_val("move_low", move_objects, 1'b0);
    check_val("move_once", move_cnt - move_base, 1);
    item_given = 5'b0;

    // Two ticks during an overlay draw.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_val("bg_again", state, 4'd3);
    status_en = 6'b000010;
    pulse_plot(); step();
    check_val("status1", draw_status, 6'b000010);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_val("overrun_two", overrun_cnt, 8'd2);
    pulse_plot(); step();
    check_val("overrun_wait", state, 4'd8);
    step();
    check_val("pending_to_bg", state, 4'd3);
    check_val("overrun_still_two", overrun_cnt, 8'd2);

    // plot_done coinciding with a tick in an overlay draw.
    status_en = 6'b000001;
    pulse_plot(); step();
    check_val("status_again", state, 4'd5);
    plot_done = 1'b1; frame_tick = 1'b1;
    step();
    plot_done = 1'b0; frame_tick = 1'b0;
    check_val("coincide_scan", state, 4'd4);
    check_val("coincide_count", overrun_cnt, 8'd3);
    step();
    check_val("coincide_wait", state, 4'd8);
    step();
    check_val("coincide_bg", state, 4'd3);

    // Saturation.
    frame_tick = 1'b1;
    for (int i = 0; i < 300; i++) step();
    frame_tick = 1'b0;
    check_val("overrun_sat", overrun_cnt, 8'd255);
    check_val("sat_bg_hold", state, 4'd3);

    // Game over handshake.
    deceased = 1'b1;
    pulse_plot();
    deceased = 1'b0;
    check_val("gameover_state", state, 4'd9);
    check_val("draw_gameover", draw_gameover, 1'b1);
    go_start = 1'b1; step(); go_start = 1'b0;
    check_val("early_go_start", state, 4'd9);
    pulse_plot();
    check_val("gameover_after_plot", state, 4'd9);
    go_start = 1'b1; step(); go_start = 1'b0;
    check_val("restart_idle", state, 4'd0);
    check_val("restart_overrun", overrun_cnt, 8'd0);

    // Reset mid item draw with a coincident plot_done.
    to_bg();
    status_en = 6'b0; item_given = 5'b00001;
    pulse_plot(); step();
    check_val("pre_rst_item", draw_item, 5'b00001);
    move_base = move_cnt;
    reset = 1'b1; plot_done = 1'b1;
    step();
    reset = 1'b0; plot_done = 1'b0;
    check_val("mid_rst_state", state, 4'd0);
    check_val("mid_rst_outs", {draw_start, draw_bg, draw_status, draw_item, draw_gameover, move_objects}, 0);
    step();
    check_val("mid_rst_hold", state, 4'd0);
    check_val("mid_rst_no_move", move_cnt - move_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
